// File: rtl/router_pkg.sv
// ============================================================================
// router_pkg : shared FSM encoding, header field positions and clog2 helper
// Revision   : 1.0
// ============================================================================
`default_nettype none

package router_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PARITY = 3'd2,
    CHECK  = 3'd3,
    DROP   = 3'd4
  } state_t;

  localparam int ADDR_LSB = 0;

  // Length field sits immediately above the destination field.
  function automatic int len_lsb(input int addr_w);
    return ADDR_LSB + addr_w;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/router_chan_fifo.sv
// ============================================================================
// router_chan_fifo : show-ahead channel FIFO with unread-timeout flush
// Revision         : 1.0
// ============================================================================
`default_nettype none

module router_chan_fifo
  import router_pkg::*;
#(
  parameter int DW      = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_rd,
  input  logic [DW-1:0] i_data,
  output logic          o_vld,
  output logic          o_full,
  output logic          o_soft_rst,
  output logic [DW-1:0] o_data
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] c_depth   = CW'(DEPTH);
  localparam logic [TW-1:0] c_timeout = TW'(TIMEOUT);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_tmr;
  logic          w_empty;
  logic          w_pop;
  logic          w_wr;
  logic          w_flush;

  assign w_empty    = (r_count == '0);
  assign o_full     = (r_count == c_depth);
  assign w_flush    = (TIMEOUT != 0) && (r_tmr == c_timeout);
  assign w_pop      = i_rd && !w_empty;
  // A push landing in the flush cycle is discarded rather than stalled.
  assign w_wr       = i_push && !o_full && !w_flush;
  assign o_vld      = !w_empty;
  assign o_soft_rst = w_flush;
  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
    end else if ((TIMEOUT == 0) || w_flush || w_empty || w_pop) begin
      r_tmr <= '0;
    end else begin
      r_tmr <= r_tmr + TW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/router_param.sv
// ============================================================================
// router_param : byte-serial packet router with parity check, backpressure,
//                invalid-destination drop and per-channel timeout flush
// Revision     : 1.0
// ============================================================================
`default_nettype none

module router_param
  import router_pkg::*;
#(
  parameter int DW      = 8,
  parameter int N_CH    = 3,
  parameter int ADDR_W  = 2,
  parameter int LEN_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 30
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               packet_valid,
  input  logic [DW-1:0]      datain,
  input  logic [N_CH-1:0]    read_enb,
  output logic               busy,
  output logic               err,
  output logic [N_CH-1:0]    vld_out,
  output logic [N_CH*DW-1:0] data_out,
  output logic [N_CH-1:0]    soft_rst
);

  localparam int LEN_LSB = len_lsb(ADDR_W);
  localparam int NPAD    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] c_n_ch = (ADDR_W + 1)'(N_CH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_dest;
  logic [ADDR_W-1:0] w_dest_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_len_nxt;
  logic [DW-1:0]     r_calc;
  logic [DW-1:0]     w_calc_nxt;
  logic [DW-1:0]     r_recv;
  logic [DW-1:0]     w_recv_nxt;
  logic              r_err;
  logic              w_err_nxt;

  logic              w_accept;
  logic              w_push;
  logic [ADDR_W-1:0] w_hdr_dest;
  logic [LEN_W-1:0]  w_hdr_len;
  logic [N_CH-1:0]   w_full;
  logic [NPAD-1:0]   w_full_pad;

  assign w_hdr_dest = datain[ADDR_LSB +: ADDR_W];
  assign w_hdr_len  = datain[LEN_LSB +: LEN_W];
  // Padding lets r_dest index safely even when N_CH < 2**ADDR_W.
  assign w_full_pad = NPAD'(w_full);
  assign busy       = (r_state == CHECK) || ((r_state == LOAD) && w_full_pad[r_dest]);
  assign w_accept   = packet_valid && !busy;
  assign w_push     = (r_state == LOAD) && w_accept;
  assign err        = r_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_dest  <= '0;
      r_len   <= '0;
      r_calc  <= '0;
      r_recv  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dest  <= w_dest_nxt;
      r_len   <= w_len_nxt;
      r_calc  <= w_calc_nxt;
      r_recv  <= w_recv_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dest_nxt  = r_dest;
    w_len_nxt   = r_len;
    w_calc_nxt  = r_calc;
    w_recv_nxt  = r_recv;
    w_err_nxt   = r_err;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_dest_nxt = w_hdr_dest;
          w_len_nxt  = w_hdr_len;
          w_calc_nxt = datain;
          if ({1'b0, w_hdr_dest} >= c_n_ch) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = DROP;
          end else begin
            w_err_nxt   = 1'b0;
            w_state_nxt = (w_hdr_len == '0) ? PARITY : LOAD;
          end
        end
      end
      LOAD: begin
        if (!packet_valid) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_accept) begin
          w_calc_nxt = r_calc ^ datain;
          w_len_nxt  = r_len - LEN_W'(1);
          if (r_len == LEN_W'(1)) w_state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (!packet_valid) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_accept) begin
          w_recv_nxt  = datain;
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        w_err_nxt   = (r_calc != r_recv);
        w_state_nxt = IDLE;
      end
      DROP: begin
        // Consumes LEN payload bytes plus the parity byte.
        if (!packet_valid) begin
          w_state_nxt = IDLE;
        end else if (w_accept) begin
          if (r_len == '0) w_state_nxt = IDLE;
          else             w_len_nxt   = r_len - LEN_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    router_chan_fifo #(
      .DW      (DW),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (resetn),
      .i_push     (w_push && (r_dest == ADDR_W'(i))),
      .i_rd       (read_enb[i]),
      .i_data     (datain),
      .o_vld      (vld_out[i]),
      .o_full     (w_full[i]),
      .o_soft_rst (soft_rst[i]),
      .o_data     (data_out[i*DW +: DW])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_router_param.sv
// ============================================================================
// tb_router_param : directed scoreboard bench for router_param
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_router_param;

  localparam int N_CH = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          packet_valid;
  logic [7:0]    datain;
  logic [2:0]    read_enb;
  logic          busy;
  logic          err;
  logic [2:0]    vld_out;
  logic [23:0]   data_out;
  logic [2:0]    soft_rst;

  int            n_vec = 0;
  int            n_err = 0;
  logic [7:0]    exp_q [N_CH][$];
  logic [7:0]    mon_exp;
  logic [7:0]    mon_got;

  router_param dut (
    .clk          (clk),
    .resetn       (resetn),
    .packet_valid (packet_valid),
    .datain       (datain),
    .read_enb     (read_enb),
    .busy         (busy),
    .err          (err),
    .vld_out      (vld_out),
    .data_out     (data_out),
    .soft_rst     (soft_rst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    packet_valid = 1'b1;
    datain       = d;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL send_stall: byte %h still busy after %0d cycles, expected accept", d, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pop_n(input int ch, input int n);
    read_enb[ch] = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    read_enb[ch] = 1'b0;
  endtask

  // Monitor: every pop the DUT performs is checked against the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (resetn && read_enb[i] && vld_out[i]) begin
        n_vec++;
        mon_got = data_out[i*8 +: 8];
        if (exp_q[i].size() == 0) begin
          n_err++;
          $display("FAIL pop_ch%0d: got %h, expected no data", i, mon_got);
        end else begin
          mon_exp = exp_q[i].pop_front();
          if (mon_got !== mon_exp) begin
            n_err++;
            $display("FAIL pop_ch%0d: got %h, expected %h", i, mon_got, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn       = 1'b0;
    packet_valid = 1'b0;
    datain       = 8'h00;
    read_enb     = 3'b000;
    #1;
    chk("rst_busy",     32'(busy),     32'h0);
    chk("rst_err",      32'(err),      32'h0);
    chk("rst_vld",      32'(vld_out),  32'h0);
    chk("rst_data",     32'(data_out), 32'h0);
    chk("rst_soft_rst", 32'(soft_rst), 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Good packet to ch1
    exp_q[1].push_back(8'hA5);
    exp_q[1].push_back(8'h3C);
    send(8'h09); send(8'hA5); send(8'h3C); send(8'h90);
    packet_valid = 1'b0;
    chk("good_check_busy", 32'(busy), 32'h1);
    @(posedge clk); #1;
    chk("good_err",  32'(err),            32'h0);
    chk("good_vld",  32'(vld_out),        32'h2);
    chk("good_head", 32'(data_out[15:8]), 32'hA5);
    pop_n(1, 2);
    chk("good_drained", 32'(vld_out), 32'h0);

    // Bad parity: data still stored, err one cycle after parity byte
    exp_q[1].push_back(8'hA5);
    exp_q[1].push_back(8'h3C);
    send(8'h09); send(8'hA5); send(8'h3C); send(8'h91);
    packet_valid = 1'b0;
    chk("bad_err_before", 32'(err), 32'h0);
    @(posedge clk); #1;
    chk("bad_err", 32'(err),     32'h1);
    chk("bad_vld", 32'(vld_out), 32'h2);
    pop_n(1, 2);

    // Backpressure: ch0, LEN=6, payload 01..06, parity 18^07=1F
    for (int b = 1; b <= 6; b++) exp_q[0].push_back(8'(b));
    send(8'h18);
    for (int b = 1; b <= 4; b++) send(8'(b));
    packet_valid = 1'b1;
    datain       = 8'h05;
    chk("bp_busy",  32'(busy),          32'h1);
    chk("bp_head",  32'(data_out[7:0]), 32'h01);
    read_enb[0] = 1'b1;
    send(8'h05); send(8'h06); send(8'h1F);
    packet_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_err", 32'(err), 32'h0);
    n = 0;
    while (vld_out[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    read_enb[0] = 1'b0;
    chk("bp_drained", 32'(vld_out), 32'h0);

    // Invalid destination: ch3 does not exist
    send(8'h07);
    chk("inv_err_hdr", 32'(err), 32'h1);
    send(8'h55); send(8'h52);
    packet_valid = 1'b0;
    chk("inv_busy", 32'(busy),    32'h0);
    chk("inv_vld",  32'(vld_out), 32'h0);
    chk("inv_err",  32'(err),     32'h1);

    // Next packet (ch2, LEN=1) confirms IDLE and seeds the timeout test
    send(8'h06); send(8'h77); send(8'h71);
    packet_valid = 1'b0;
    @(posedge clk); #1;
    chk("to_err", 32'(err),     32'h0);
    chk("to_vld", 32'(vld_out), 32'h4);
    repeat (27) @(posedge clk);
    #1;
    chk("to_pre_soft", 32'(soft_rst), 32'h0);
    @(posedge clk); #1;
    chk("to_soft",     32'(soft_rst), 32'h4);
    chk("to_vld_held", 32'(vld_out),  32'h4);
    @(posedge clk); #1;
    chk("to_soft_end", 32'(soft_rst), 32'h0);
    chk("to_flushed",  32'(vld_out),  32'h0);

    // Abort mid-LOAD: pushed byte stays, err set
    exp_q[1].push_back(8'hB1);
    send(8'h0D); send(8'hB1);
    packet_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_err", 32'(err),            32'h1);
    chk("abort_vld", 32'(vld_out),        32'h2);
    chk("abort_dat", 32'(data_out[15:8]), 32'hB1);
    pop_n(1, 1);

    // Asynchronous reset mid-LOAD
    send(8'h09); send(8'hA5);
    chk("ar_vld_pre", 32'(vld_out), 32'h2);
    #3;
    resetn       = 1'b0;
    packet_valid = 1'b0;
    #1;
    chk("ar_busy", 32'(busy),     32'h0);
    chk("ar_err",  32'(err),      32'h0);
    chk("ar_vld",  32'(vld_out),  32'h0);
    chk("ar_data", 32'(data_out), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    exp_q[1].push_back(8'hA5);
    exp_q[1].push_back(8'h3C);
    send(8'h09); send(8'hA5); send(8'h3C); send(8'h90);
    packet_valid = 1'b0;
    @(posedge clk); #1;
    chk("ar_good_err", 32'(err),     32'h0);
    chk("ar_good_vld", 32'(vld_out), 32'h2);
    pop_n(1, 2);

    @(posedge clk); #1;
    for (int i = 0; i < N_CH; i++) chk("sb_empty", 32'(exp_q[i].size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
